// File: rtl/vec_lsu.sv
// vec_lsu: vector load/store unit; sequences VRAM reads/writes for one request at a time.
// Byte-strided access is built only when VEC_LSU_STRIDE_EN is defined; otherwise every request is unit-stride.
module vec_lsu #(
    parameter int VLEN = 256,
    parameter int SEW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic            req_strided,
    input  logic [31:0]     req_base,
    input  logic [31:0]     req_stride,
    input  logic [VLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [VLEN-1:0] resp_rdata,
    output logic            vram_r_ena,
    output logic [31:0]     vram_r_addr,
    input  logic [VLEN-1:0] vram_r_data,
    output logic            vram_w_ena,
    output logic [31:0]     vram_w_addr,
    output logic [VLEN-1:0] vram_w_data,
    output logic [VLEN-1:0] vram_w_mask
);
    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // LOAD  | issuing reads and capturing returned data
    // STORE | issuing writes, one per cycle
    // RESP  | response held until resp_ready
    localparam int NELEM = VLEN / SEW;
    localparam logic [VLEN-1:0] ELEM_MASK = {{(VLEN - SEW){1'b0}}, {SEW{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]     addr_q;
    logic [VLEN-1:0] wdata_q;
    logic [VLEN-1:0] rdata_q;
    logic            rd_pend_q;
    logic [31:0]     stride_step;
    logic            strided;
    logic            more_issue;
    logic            last_issue;
    logic            last_capture;
    logic            accept;
    logic            rd_issue;
    logic            wr_issue;
    logic            capture;

`ifdef VEC_LSU_STRIDE_EN
    logic        strided_q;
    logic [31:0] stride_q;
    logic [3:0]  ic;
    logic [3:0]  cc;

    assign strided      = strided_q;
    assign stride_step  = stride_q;
    assign more_issue   = strided_q ? (ic < 4'(NELEM)) : (ic == 4'd0);
    assign last_issue   = strided_q ? (ic == 4'(NELEM - 1)) : 1'b1;
    assign last_capture = strided_q ? (cc == 4'(NELEM - 1)) : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strided_q <= 1'b0;
            stride_q  <= '0;
            ic        <= '0;
            cc        <= '0;
        end else if (accept) begin
            strided_q <= req_strided;
            stride_q  <= req_stride;
            ic        <= '0;
            cc        <= '0;
        end else begin
            if (rd_issue || wr_issue)
                ic <= ic + 4'd1;
            if (capture)
                cc <= cc + 4'd1;
        end
    end
`else
    logic unused_stride;
    assign unused_stride = ^{req_strided, req_stride};

    assign strided      = 1'b0;
    assign stride_step  = 32'd0;
    // one read in flight at most: rd_pend_q doubles as the "already issued" flag
    assign more_issue   = !rd_pend_q;
    assign last_issue   = 1'b1;
    assign last_capture = 1'b1;
`endif

    assign accept   = (state == S_IDLE) && req_valid;
    assign rd_issue = (state == S_LOAD) && more_issue;
    assign wr_issue = (state == S_STORE);
    assign capture  = (state == S_LOAD) && rd_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = req_store ? S_STORE : S_LOAD;
            S_LOAD:  if (capture && last_capture) state_nxt = S_RESP;
            S_STORE: if (last_issue) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // addr_q walks by the stride on every issue; store data shifts down so element i sits at the bottom
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_pend_q <= 1'b0;
        end else if (accept) begin
            addr_q    <= req_base;
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_issue;
            if (rd_issue || wr_issue)
                addr_q <= addr_q + stride_step;
            if (wr_issue && strided)
                wdata_q <= wdata_q >> SEW;
            if (capture)
                rdata_q <= strided ? {vram_r_data[SEW-1:0], rdata_q[VLEN-1:SEW]} : vram_r_data;
        end
    end

    assign req_ready   = (state == S_IDLE) && !rst;
    assign resp_valid  = (state == S_RESP);
    assign resp_rdata  = (state == S_RESP) ? rdata_q : '0;

    assign vram_r_ena  = rd_issue;
    assign vram_r_addr = rd_issue ? addr_q : '0;
    assign vram_w_ena  = wr_issue;
    assign vram_w_addr = wr_issue ? addr_q : '0;
    assign vram_w_data = !wr_issue ? '0 : (strided ? (wdata_q & ELEM_MASK) : wdata_q);
    assign vram_w_mask = !wr_issue ? '0 : (strided ? ELEM_MASK : '1);

endmodule
